// File: rtl/seg_scan_driver_pkg.sv
// Shared seven-segment codes (active-low, bit6=a ... bit0=g) for the display blocks.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b1100000;
  localparam logic [6:0] SEG_C    = 7'b0110001;
  localparam logic [6:0] SEG_D    = 7'b1000010;
  localparam logic [6:0] SEG_E    = 7'b0110000;
  localparam logic [6:0] SEG_F    = 7'b0111000;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit value to active-low segment pattern; values above 9 are
// letters in hex mode, a dash otherwise.
module seg_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
      4'hF: seg = hex_mode ? SEG_F : SEG_DASH;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Self-scanning N-digit seven-segment driver: prescaler, digit scan, frame-coherent
// shadow of the display inputs, blink, leading-zero blanking and anode dead-time.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 1000,
  parameter int BLINK_FRAMES = 100,
  parameter int HEX_MODE     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzb,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode_active,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD       = PW'(DEAD_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic          HEX        = (HEX_MODE != 0);

  logic [PW-1:0]           presc;
  logic [SW-1:0]           slot;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] sh_num;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lzb;

  logic                    slot_wrap;
  logic                    frame_end;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   lzb_sup;
  logic [3:0]              cur_val;
  logic                    dark;
  logic [6:0]              dec_seg;

  assign slot_wrap = (presc == PRE_LAST);
  assign frame_end = slot_wrap && (slot == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      slot        <= SLOT_LAST;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_num      <= '0;
      sh_dp       <= '0;
      sh_blank    <= '1;
      sh_blink    <= '0;
      sh_lzb      <= 1'b0;
    end else begin
      presc <= slot_wrap ? '0 : presc + PW'(1);
      if (slot_wrap) begin
        slot <= (slot == '0) ? SLOT_LAST : slot - SW'(1);
      end
      // Inputs are sampled only at the frame boundary so a frame never shows mixed data.
      if (frame_end) begin
        sh_num   <= num;
        sh_dp    <= dp_in;
        sh_blank <= blank;
        sh_blink <= blink_en;
        sh_lzb   <= lzb;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Walk from the leftmost digit down; a digit is suppressed while everything above is zero.
  always_comb begin
    all_zero = 1'b1;
    lzb_sup  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (sh_num[4*i +: 4] == 4'd0);
      lzb_sup[i] = sh_lzb & all_zero;
    end
  end

  assign cur_val = sh_num[{slot, 2'b00} +: 4];
  assign dark    = sh_blank[slot] | (blink_phase & sh_blink[slot]) | lzb_sup[slot];

  seg_decode u_decode (
    .value    (cur_val),
    .hex_mode (HEX),
    .seg      (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments     <= SEG_OFF;
      dp_n         <= 1'b1;
      anode_active <= '1;
      frame_start  <= 1'b0;
    end else begin
      segments     <= dark ? SEG_OFF : dec_seg;
      dp_n         <= dark | ~sh_dp[slot];
      anode_active <= (presc < DEAD) ? '1 : ~(NUM_DIGITS'(1) << slot);
      frame_start  <= (slot == SLOT_LAST) && (presc == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: one hex-mode and one decimal-mode instance share stimulus;
// a per-frame scoreboard checks every output cycle of every frame.
module tb_seg_scan_driver;

  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int BF   = 2;
  localparam int FLEN = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] num;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  blink_en;
  logic        lzb;

  logic [6:0]  seg_h, seg_d;
  logic        dp_h, dp_d;
  logic [3:0]  an_h, an_d;
  logic        fs_h, fs_d;

  int          n_tests = 0;
  int          n_fail = 0;
  int          mon_k = 0;
  int          frame_idx = 0;
  int          mon_slot;
  int          mon_p;
  logic [3:0]  an_exp;
  string       cur_test = "init";

  // Entry per digit slot: {hex-mode segments, decimal-mode segments, dp_n}
  logic [14:0] exp_q[$];
  logic [14:0] cur_exp;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(DIV), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF), .HEX_MODE(1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .num(num), .dp_in(dp_in), .blank(blank),
    .blink_en(blink_en), .lzb(lzb), .segments(seg_h), .dp_n(dp_h),
    .anode_active(an_h), .frame_start(fs_h)
  );

  seg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(DIV), .DEAD_CYCLES(DEAD), .BLINK_FRAMES(BF), .HEX_MODE(0)
  ) dut_dec (
    .clk(clk), .rst_n(rst_n), .num(num), .dp_in(dp_in), .blank(blank),
    .blink_en(blink_en), .lzb(lzb), .segments(seg_d), .dp_n(dp_d),
    .anode_active(an_d), .frame_start(fs_d)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] v, input bit hex);
    logic [6:0] r;
    case (v)
      4'd0:  r = 7'b0000001;
      4'd1:  r = 7'b1001111;
      4'd2:  r = 7'b0010010;
      4'd3:  r = 7'b0000110;
      4'd4:  r = 7'b1001100;
      4'd5:  r = 7'b0100100;
      4'd6:  r = 7'b0100000;
      4'd7:  r = 7'b0001111;
      4'd8:  r = 7'b0000000;
      4'd9:  r = 7'b0000100;
      4'd10: r = hex ? 7'b0001000 : 7'b1111110;
      4'd11: r = hex ? 7'b1100000 : 7'b1111110;
      4'd12: r = hex ? 7'b0110001 : 7'b1111110;
      4'd13: r = hex ? 7'b1000010 : 7'b1111110;
      4'd14: r = hex ? 7'b0110000 : 7'b1111110;
      default: r = hex ? 7'b0111000 : 7'b1111110;
    endcase
    return r;
  endfunction

  // Expected content of frame f, pushed in scan order (digit 3 first).
  task automatic push_frame(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b,
                            input logic [3:0] k, input logic l, input int f);
    bit         ph;
    bit         sup;
    bit         drk;
    logic [3:0] v;
    ph = ((f / BF) % 2) == 1;
    for (int i = N - 1; i >= 0; i--) begin
      v   = n[4*i +: 4];
      sup = l && (i >= 1) && ((n >> (4*i)) == 16'd0);
      drk = b[i] || (ph && k[i]) || sup;
      exp_q.push_back({drk ? 7'h7F : ref_seg(v, 1'b1),
                       drk ? 7'h7F : ref_seg(v, 1'b0),
                       drk ? 1'b1  : ~d[i]});
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, one output cycle per sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_k     = 0;
      frame_idx = 0;
      exp_q.delete();
    end else begin
      mon_slot = N - 1 - mon_k / DIV;
      mon_p    = mon_k % DIV;
      if (mon_p == 0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          cur_exp = '1;
          $display("FAIL %s sb_underflow frame %0d slot %0d: queue empty, need one entry",
                   cur_test, frame_idx, mon_slot);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      an_exp = 4'hF;
      if (mon_p >= DEAD) an_exp[mon_slot] = 1'b0;
      n_tests += 4;
      if (fs_h !== (mon_k == 0)) begin
        n_fail++;
        $display("FAIL %s frame_start_hex frame %0d k %0d: got %b want %b",
                 cur_test, frame_idx, mon_k, fs_h, (mon_k == 0));
      end
      if (fs_d !== (mon_k == 0)) begin
        n_fail++;
        $display("FAIL %s frame_start_dec frame %0d k %0d: got %b want %b",
                 cur_test, frame_idx, mon_k, fs_d, (mon_k == 0));
      end
      if (an_h !== an_exp) begin
        n_fail++;
        $display("FAIL %s anode_hex frame %0d k %0d: got %b want %b",
                 cur_test, frame_idx, mon_k, an_h, an_exp);
      end
      if (an_d !== an_exp) begin
        n_fail++;
        $display("FAIL %s anode_dec frame %0d k %0d: got %b want %b",
                 cur_test, frame_idx, mon_k, an_d, an_exp);
      end
      if (mon_p >= DEAD) begin
        n_tests += 4;
        if (seg_h !== cur_exp[14:8]) begin
          n_fail++;
          $display("FAIL %s seg_hex frame %0d k %0d: got %b want %b",
                   cur_test, frame_idx, mon_k, seg_h, cur_exp[14:8]);
        end
        if (seg_d !== cur_exp[7:1]) begin
          n_fail++;
          $display("FAIL %s seg_dec frame %0d k %0d: got %b want %b",
                   cur_test, frame_idx, mon_k, seg_d, cur_exp[7:1]);
        end
        if (dp_h !== cur_exp[0]) begin
          n_fail++;
          $display("FAIL %s dp_hex frame %0d k %0d: got %b want %b",
                   cur_test, frame_idx, mon_k, dp_h, cur_exp[0]);
        end
        if (dp_d !== cur_exp[0]) begin
          n_fail++;
          $display("FAIL %s dp_dec frame %0d k %0d: got %b want %b",
                   cur_test, frame_idx, mon_k, dp_d, cur_exp[0]);
        end
      end
      if (mon_k == FLEN - 1) begin
        mon_k = 0;
        frame_idx++;
      end else begin
        mon_k++;
      end
    end
  end

  // Drive one frame's worth of inputs at a random point inside the current frame;
  // they become visible in the following frame. Returns at the frame boundary.
  task automatic drive_frame(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b,
                             input logic [3:0] k, input logic l);
    int pos;
    bit hit;
    pos = $urandom_range(1, FLEN - 1);
    hit = 1'b0;
    for (int t = 0; t < FLEN + 8 && !hit; t++) begin
      @(negedge clk);
      #1;
      if (mon_k == pos) hit = 1'b1;
    end
    num      = n;
    dp_in    = d;
    blank    = b;
    blink_en = k;
    lzb      = l;
    push_frame(n, d, b, k, l, frame_idx + 1);
    hit = 1'b0;
    for (int t = 0; t < FLEN + 8 && !hit; t++) begin
      @(negedge clk);
      #1;
      if (mon_k == 0) hit = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_tests += 5;
    if (seg_h !== 7'h7F) begin
      n_fail++;
      $display("FAIL %s seg_hex: got %b want 1111111", tag, seg_h);
    end
    if (seg_d !== 7'h7F) begin
      n_fail++;
      $display("FAIL %s seg_dec: got %b want 1111111", tag, seg_d);
    end
    if (dp_h !== 1'b1) begin
      n_fail++;
      $display("FAIL %s dp_n: got %b want 1", tag, dp_h);
    end
    if (an_h !== 4'hF) begin
      n_fail++;
      $display("FAIL %s anode: got %b want 1111", tag, an_h);
    end
    if (fs_h !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_start: got %b want 0", tag, fs_h);
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    num      = 16'h0000;
    dp_in    = 4'h0;
    blank    = 4'h0;
    blink_en = 4'h0;
    lzb      = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset_hold");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 0);
  endtask

  task automatic test_scan();
    cur_test = "scan_1234";
    drive_frame(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    cur_test = "mid_frame_change";
    drive_frame(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);
    drive_frame(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_lzb();
    cur_test = "lzb";
    drive_frame(16'h0007, 4'h0, 4'h0, 4'h0, 1'b1);
    drive_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
    drive_frame(16'h0070, 4'hF, 4'h0, 4'h0, 1'b1);
    drive_frame(16'h0007, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_hex();
    cur_test = "hex_decode";
    drive_frame(16'hABCD, 4'h0, 4'h0, 4'h0, 1'b0);
    drive_frame(16'hEF90, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_blink();
    cur_test = "blink";
    repeat (6) drive_frame(16'h1234, 4'b0100, 4'h0, 4'b0011, 1'b0);
  endtask

  task automatic test_reset_mid_blink();
    bit hit;
    cur_test = "reset_mid_blink";
    hit = 1'b0;
    for (int t = 0; t < FLEN + 8 && !hit; t++) begin
      @(negedge clk);
      #1;
      if (mon_k == 13) hit = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 0);
    repeat (4) drive_frame(16'h1234, 4'b0100, 4'h0, 4'b0011, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] n;
    logic [3:0]  d;
    logic [3:0]  b;
    logic [3:0]  k;
    cur_test = "random";
    for (int r = 0; r < 6; r++) begin
      n = 16'($urandom);
      if (r % 2 == 1) n[15:8] = 8'h00;
      d = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      k = 4'($urandom_range(0, 15));
      drive_frame(n, d, b, k, 1'($urandom_range(0, 1)));
    end
    cur_test = "flush";
    drive_frame(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_back_to_back();
    test_lzb();
    test_hex();
    test_blink();
    test_reset_mid_blink();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
